// File: rtl/axi_pkg.sv
// AXI4 parameters and the flattened request/response structs used by the single-beat DMA master.
package axi_pkg;
  localparam int DATA_BUS_WIDTH = 64;
  localparam int ID_BUS_WIDTH   = 4;
  localparam int ADDR_W         = 32;
  localparam int STRB_W         = DATA_BUS_WIDTH / 8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_BUS_WIDTH-1:0]   aw_id;
    logic [ADDR_W-1:0]         aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_valid;
    logic [DATA_BUS_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]         w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      b_ready;
    logic [ID_BUS_WIDTH-1:0]   ar_id;
    logic [ADDR_W-1:0]         ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_valid;
    logic                      r_ready;
  } axi_req_t;

  typedef struct packed {
    logic                      aw_ready;
    logic                      w_ready;
    logic [ID_BUS_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic                      b_valid;
    logic                      ar_ready;
    logic [ID_BUS_WIDTH-1:0]   r_id;
    logic [DATA_BUS_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic                      r_valid;
  } axi_resp_t;
endpackage

// File: rtl/dma_pkg.sv
// DMA descriptor/status/error types, FSM states and beat geometry.
package dma_pkg;
  localparam int BYTES   = axi_pkg::DATA_BUS_WIDTH / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int CHUNK_W = OFF_W + 1;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic busy;
    logic done;
  } s_dma_status_t;

  typedef struct packed {
    logic        rd_err;
    logic        wr_err;
    logic [31:0] err_addr;
  } s_dma_error_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_AR, S_RD_R, S_WR_AW_W, S_WR_B, S_DONE
  } dma_state_e;
endpackage

// File: rtl/dma_copy_engine_if.sv
// AXI master bundle between the DMA engine and the downstream master mux.
interface dma_copy_engine_if;
  axi_pkg::axi_req_t  req;
  axi_pkg::axi_resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/dma_byte_aligner.sv
// Rotates a read beat into destination lane order and builds the write strobe for one chunk.
module dma_byte_aligner
  import axi_pkg::*;
  import dma_pkg::*;
(
  input  logic [DATA_BUS_WIDTH-1:0] rdata_i,
  input  logic [OFF_W-1:0]          src_off_i,
  input  logic [OFF_W-1:0]          dst_off_i,
  input  logic [CHUNK_W-1:0]        chunk_i,
  output logic [DATA_BUS_WIDTH-1:0] wdata_o,
  output logic [BYTES-1:0]          wstrb_o
);
  logic [OFF_W-1:0]   shift;
  logic [CHUNK_W:0]   hi;

  // OFF_W-bit subtraction wraps, giving the rotation mod BYTES for free
  assign shift = dst_off_i - src_off_i;
  assign hi    = {2'b00, dst_off_i} + {1'b0, chunk_i};

  for (genvar d = 0; d < BYTES; d++) begin : g_lane
    logic [OFF_W-1:0] s;
    assign s = OFF_W'(d) - shift;
    assign wdata_o[d*8 +: 8] = rdata_i[{s, 3'b000} +: 8];
    assign wstrb_o[d] = (OFF_W'(d) >= dst_off_i) && ((CHUNK_W+1)'(d) < hi);
  end
endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel memory-to-memory DMA: one single-beat read then one single-beat write per chunk,
// where a chunk never crosses a beat boundary on either side.
module dma_copy_engine
  import axi_pkg::*;
  import dma_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dma_go_i,
  input  s_dma_desc_t             dma_desc_i,
  output s_dma_status_t           dma_stats_o,
  output s_dma_error_t            dma_error_o,
  dma_copy_engine_if.master       axi_if
);
  dma_state_e                state_q, state_d;
  logic [31:0]               src_q, src_d, dst_q, dst_d, rem_q, rem_d;
  logic [DATA_BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  s_dma_status_t             stat_q, stat_d;
  s_dma_error_t              err_q, err_d;

  logic [OFF_W-1:0]          src_off, dst_off;
  logic [CHUNK_W-1:0]        src_room, dst_room, room, chunk;
  logic [DATA_BUS_WIDTH-1:0] wdata;
  logic [BYTES-1:0]          wstrb;
  logic                      aw_vld, w_vld, aw_fire, w_fire;
  logic                      unused_resp;

  assign src_off  = src_q[OFF_W-1:0];
  assign dst_off  = dst_q[OFF_W-1:0];
  assign src_room = CHUNK_W'(BYTES) - {1'b0, src_off};
  assign dst_room = CHUNK_W'(BYTES) - {1'b0, dst_off};
  assign room     = (src_room < dst_room) ? src_room : dst_room;
  assign chunk    = (rem_q < 32'(room)) ? rem_q[CHUNK_W-1:0] : room;

  dma_byte_aligner u_align (
    .rdata_i   (rdata_q),
    .src_off_i (src_off),
    .dst_off_i (dst_off),
    .chunk_i   (chunk),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb)
  );

  assign aw_vld  = (state_q == S_WR_AW_W) && !aw_done_q;
  assign w_vld   = (state_q == S_WR_AW_W) && !w_done_q;
  assign aw_fire = aw_vld && axi_if.resp.aw_ready;
  assign w_fire  = w_vld && axi_if.resp.w_ready;
  assign unused_resp = ^{axi_if.resp.b_id, axi_if.resp.r_id, axi_if.resp.r_last};

  always_comb begin
    axi_if.req          = '0;
    axi_if.req.ar_addr  = {src_q[31:OFF_W], {OFF_W{1'b0}}};
    axi_if.req.ar_size  = 3'(OFF_W);
    axi_if.req.ar_burst = BURST_INCR;
    axi_if.req.ar_valid = (state_q == S_RD_AR);
    axi_if.req.r_ready  = (state_q == S_RD_R);
    axi_if.req.aw_addr  = {dst_q[31:OFF_W], {OFF_W{1'b0}}};
    axi_if.req.aw_size  = 3'(OFF_W);
    axi_if.req.aw_burst = BURST_INCR;
    axi_if.req.aw_valid = aw_vld;
    axi_if.req.w_data   = wdata;
    axi_if.req.w_strb   = wstrb;
    axi_if.req.w_last   = 1'b1;
    axi_if.req.w_valid  = w_vld;
    axi_if.req.b_ready  = (state_q == S_WR_B);
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    stat_d    = stat_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: if (dma_go_i) begin
        src_d       = dma_desc_i.src_addr;
        dst_d       = dma_desc_i.dst_addr;
        rem_d       = dma_desc_i.num_bytes;
        stat_d.busy = 1'b1;
        stat_d.done = 1'b0;
        err_d       = '0;
        state_d     = (dma_desc_i.num_bytes == '0) ? S_DONE : S_RD_AR;
      end
      S_RD_AR: if (axi_if.resp.ar_ready) state_d = S_RD_R;
      S_RD_R: if (axi_if.resp.r_valid) begin
        rdata_d   = axi_if.resp.r_data;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (axi_if.resp.r_resp != RESP_OKAY) begin
          err_d.rd_err   = 1'b1;
          err_d.err_addr = src_q;
          state_d        = S_DONE;
        end else begin
          state_d = S_WR_AW_W;
        end
      end
      S_WR_AW_W: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_B;
        end
      end
      S_WR_B: if (axi_if.resp.b_valid) begin
        if (axi_if.resp.b_resp != RESP_OKAY) begin
          err_d.wr_err   = 1'b1;
          err_d.err_addr = dst_q;
          state_d        = S_DONE;
        end else begin
          src_d   = src_q + 32'(chunk);
          dst_d   = dst_q + 32'(chunk);
          rem_d   = rem_q - 32'(chunk);
          state_d = (rem_q == 32'(chunk)) ? S_DONE : S_RD_AR;
        end
      end
      S_DONE: begin
        stat_d.busy = 1'b0;
        stat_d.done = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      stat_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      stat_q    <= stat_d;
      err_q     <= err_d;
    end
  end

  assign dma_stats_o = stat_q;
  assign dma_error_o = err_q;
endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a single-beat AXI RAM model behind the master port.
module tb_dma_copy_engine;
  import axi_pkg::*;
  import dma_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          dma_go;
  s_dma_desc_t   desc;
  s_dma_status_t stats;
  s_dma_error_t  err;

  always #5 clk = ~clk;

  dma_copy_engine_if axi_if ();

  dma_copy_engine dut (
    .clk         (clk),
    .rst         (rst),
    .dma_go_i    (dma_go),
    .dma_desc_i  (desc),
    .dma_stats_o (stats),
    .dma_error_o (err),
    .axi_if      (axi_if)
  );

  int checks = 0;
  int errors = 0;

  // RAM windows: 0x1100_0000 (1 KiB, source) and 0x1400_0000 (1 KiB, destination)
  logic [7:0]  mem [0:2047];
  logic        init_mem, clr_mon, rd_err_inj, wr_err_inj;
  logic        s_rvalid, s_bvalid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  int          ar_cnt, aw_cnt, w_cnt;
  logic        any_valid;
  logic [7:0]  wstrb_log [0:15];

  function automatic int idx(input logic [31:0] a);
    if ((a & 32'hFFFF_FC00) == 32'h1100_0000) return int'(a[9:0]);
    if ((a & 32'hFFFF_FC00) == 32'h1400_0000) return 1024 + int'(a[9:0]);
    return -1;
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    int i;
    i = idx(a);
    if (i < 0) return 8'h00;
    return mem[i];
  endfunction

  always_comb begin
    axi_if.resp          = '0;
    axi_if.resp.aw_ready = 1'b1;
    axi_if.resp.w_ready  = 1'b1;
    axi_if.resp.ar_ready = 1'b1;
    axi_if.resp.r_valid  = s_rvalid;
    axi_if.resp.r_data   = s_rdata;
    axi_if.resp.r_resp   = s_rresp;
    axi_if.resp.r_last   = 1'b1;
    axi_if.resp.b_valid  = s_bvalid;
    axi_if.resp.b_resp   = s_bresp;
  end

  always @(posedge clk) begin
    if (init_mem)
      for (int i = 0; i < 2048; i++) mem[i] <= (i < 1024) ? 8'(i) : 8'hEE;
    if (clr_mon) begin
      ar_cnt    <= 0;
      aw_cnt    <= 0;
      w_cnt     <= 0;
      any_valid <= 1'b0;
    end
    if (rst) begin
      s_rvalid <= 1'b0;
      s_bvalid <= 1'b0;
    end else begin
      if (axi_if.req.ar_valid || axi_if.req.aw_valid || axi_if.req.w_valid) any_valid <= 1'b1;
      if (s_rvalid && axi_if.req.r_ready) s_rvalid <= 1'b0;
      if (s_bvalid && axi_if.req.b_ready) s_bvalid <= 1'b0;
      if (axi_if.req.ar_valid) begin
        ar_cnt   <= ar_cnt + 1;
        s_rvalid <= 1'b1;
        s_rresp  <= rd_err_inj ? RESP_SLVERR : RESP_OKAY;
        for (int b = 0; b < 8; b++) s_rdata[b*8 +: 8] <= rd(axi_if.req.ar_addr + 32'(b));
      end
      if (axi_if.req.aw_valid) aw_cnt <= aw_cnt + 1;
      if (axi_if.req.w_valid) begin
        w_cnt                    <= w_cnt + 1;
        wstrb_log[w_cnt[3:0]]    <= axi_if.req.w_strb;
        s_bvalid                 <= 1'b1;
        s_bresp                  <= wr_err_inj ? RESP_SLVERR : RESP_OKAY;
        for (int b = 0; b < 8; b++)
          if (axi_if.req.w_strb[b] && idx(axi_if.req.aw_addr + 32'(b)) >= 0)
            mem[idx(axi_if.req.aw_addr + 32'(b))] <= axi_if.req.w_data[b*8 +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    tick();
    clr_mon = 1'b0;
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    desc   = '{src_addr: s, dst_addr: d, num_bytes: n};
    dma_go = 1'b1;
    tick();
    dma_go = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (!(stats.done && !stats.busy) && n < max) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, stats.done}, 64'd1);
  endtask

  function automatic logic [4:0] valids();
    return {axi_if.req.ar_valid, axi_if.req.aw_valid, axi_if.req.w_valid,
            axi_if.req.r_ready, axi_if.req.b_ready};
  endfunction

  initial begin
    rst = 1'b1; dma_go = 1'b0; desc = '0;
    init_mem = 1'b1; clr_mon = 1'b1; rd_err_inj = 1'b0; wr_err_inj = 1'b0;
    tick(); tick();
    chk("reset_valids", 64'(valids()), 64'd0);
    chk("reset_busy", 64'(stats.busy), 64'd0);
    chk("reset_done", 64'(stats.done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    init_mem = 1'b0; clr_mon = 1'b0; rst = 1'b0;
    tick();

    // unaligned: src off 3, dst off 7 -> chunks 1,4,4,2
    go(32'h1100_011B, 32'h1400_0127, 32'd11);
    wait_done(60, "unal_done");
    chk("unal_err", 64'(err), 64'd0);
    for (int i = 0; i < 11; i++) chk($sformatf("unal_byte%0d", i), 64'(rd(32'h1400_0127 + 32'(i))), 64'(8'h1B + 8'(i)));
    chk("unal_below", 64'(rd(32'h1400_0126)), 64'hEE);
    chk("unal_above", 64'(rd(32'h1400_0132)), 64'hEE);
    chk("unal_nwr", 64'(w_cnt), 64'd4);
    chk("unal_strbs", {32'd0, wstrb_log[0], wstrb_log[1], wstrb_log[2], wstrb_log[3]}, 64'h800F_F003);

    clear_mon();
    go(32'h1100_0100, 32'h1400_0100, 32'd64);
    wait_done(200, "alig_done");
    chk("alig_naw", 64'(aw_cnt), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("alig_strb%0d", i), 64'(wstrb_log[i]), 64'hFF);
    for (int i = 0; i < 64; i += 9) chk($sformatf("alig_byte%0d", i), 64'(rd(32'h1400_0100 + 32'(i))), 64'(i));
    chk("alig_last", 64'(rd(32'h1400_013F)), 64'h3F);

    clear_mon();
    go(32'h1100_0100, 32'h1400_0300, 32'd0);
    chk("zero_busy", 64'(stats), 64'b10);
    tick();
    chk("zero_done", 64'(stats), 64'b01);
    chk("zero_novalid", 64'(any_valid), 64'd0);

    clear_mon();
    rd_err_inj = 1'b1;
    go(32'h1100_0108, 32'h1400_0200, 32'd16);
    wait_done(60, "rderr_done");
    chk("rderr_err", 64'(err), {30'd0, 2'b10, 32'h1100_0108});
    chk("rderr_noaw", 64'(aw_cnt), 64'd0);
    rd_err_inj = 1'b0;

    wr_err_inj = 1'b1;
    go(32'h1100_0110, 32'h1400_0208, 32'd8);
    wait_done(60, "wrerr_done");
    chk("wrerr_err", 64'(err), {30'd0, 2'b01, 32'h1400_0208});
    wr_err_inj = 1'b0;

    // second go lands while the engine is mid-transfer and must be dropped
    clear_mon();
    go(32'h1100_0100, 32'h1400_0200, 32'd16);
    tick(); tick();
    go(32'h1100_0120, 32'h1400_0300, 32'd8);
    wait_done(60, "busy_done");
    chk("busy_naw", 64'(aw_cnt), 64'd2);
    chk("busy_err", 64'(err), 64'd0);
    for (int i = 0; i < 16; i += 5) chk($sformatf("busy_byte%0d", i), 64'(rd(32'h1400_0200 + 32'(i))), 64'(i));
    chk("busy_other", 64'(rd(32'h1400_0300)), 64'hEE);

    clear_mon();
    go(32'h1100_0100, 32'h1400_0340, 32'd16);
    begin
      int n = 0;
      while (!axi_if.req.aw_valid && n < 20) begin tick(); n++; end
    end
    chk("rst_reach_aw", 64'(axi_if.req.aw_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valids", 64'(valids()), 64'd0);
    chk("rst_stats", 64'(stats), 64'd0);
    go(32'h1100_0130, 32'h1400_0380, 32'd8);
    wait_done(60, "rst_go_done");
    chk("rst_go_err", 64'(err), 64'd0);
    for (int i = 0; i < 8; i += 7) chk($sformatf("rst_go_byte%0d", i), 64'(rd(32'h1400_0380 + 32'(i))), 64'(8'h30 + 8'(i)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Single-channel memory-to-memory DMA. Copies num_bytes from src_addr to dst_addr over one AXI4 master port.
- Supports arbitrary byte alignment of source, destination and length.
- Sits behind a CSR block that supplies the descriptor and a go pulse.
- Its AXI port feeds a 2:1 master mux in front of the system RAM.

Parameters:
- DATA_BUS_WIDTH, 64 (from axi_pkg): AXI data width in bits. BYTES = DATA_BUS_WIDTH/8; OFF_W = log2(BYTES).
- ID_BUS_WIDTH, 4 (from axi_pkg): AXI ID width. All transactions use ID 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dma_go_i  in  1  start pulse, sampled only in IDLE
- dma_desc_i  in  s_dma_desc_t  {src_addr[31:0], dst_addr[31:0], num_bytes[31:0]}, captured on accepted go
- dma_stats_o  out  s_dma_status_t  {busy, done}
- dma_error_o  out  s_dma_error_t  {rd_err, wr_err, err_addr[31:0]}
- axi_req_o  out  axi_req_t  AW/W/AR channels plus bready/rready
- axi_resp_i  in  axi_resp_t  awready/wready/arready plus B/R channels

Behaviour:
- Reset (synchronous, rst=1): state IDLE.
  - All AXI valid signals 0; bready and rready 0.
  - busy=0, done=0, rd_err=0, wr_err=0, err_addr=0.
  - Reset mid-transfer aborts immediately; no partial-state recovery.
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- IDLE:
  - dma_go_i=1 at a clock edge latches the descriptor into cur_src, cur_dst and remaining, clears done and the error fields, and sets busy=1.
  - If num_bytes==0, go directly to DONE. Otherwise go to RD_AR.
- Chunk size: chunk = min(remaining, BYTES - cur_src[OFF_W-1:0], BYTES - cur_dst[OFF_W-1:0]). Every chunk is 1..BYTES bytes and crosses no beat boundary on either side.
- RD_AR: AR request is single-beat.
  - araddr = cur_src with low OFF_W bits cleared; arlen=0, arsize=OFF_W, arburst=INCR, arid=0.
  - arvalid is held until arready. Go to RD_R.
- RD_R: rready=1.
  - On rvalid, capture rdata.
  - rresp != OKAY: rd_err=1, err_addr=cur_src, go to DONE.
  - Otherwise go to WR_AW_W.
- WR_AW_W: awvalid and wvalid asserted together; each drops independently on its own ready.
  - awaddr = cur_dst aligned, awlen=0, awsize=OFF_W, awburst=INCR, wlast=1.
  - wdata = captured rdata byte-rotated so that source lane s maps to lane s + (dst_off - src_off) mod BYTES.
  - wstrb = ((1<<chunk)-1) << dst_off.
  - When both handshakes are complete, go to WR_B.
- WR_B: bready=1.
  - On bvalid with bresp != OKAY: wr_err=1, err_addr=cur_dst, go to DONE.
  - Otherwise: cur_src+=chunk, cur_dst+=chunk, remaining-=chunk. Go to RD_AR if remaining>0, else DONE.
- DONE: busy=0, done=1. Go to IDLE.
- done is sticky: it stays 1 until the next accepted go or reset.
- dma_go_i while busy is ignored.
- Address arithmetic is 32-bit with wrap modulo 2^32.
- Only one AXI transaction is outstanding at a time. Reads never overlap writes.

Decomposition:
- dma_pkg: s_dma_desc_t, s_dma_status_t, s_dma_error_t.
- axi_pkg: axi_req_t, axi_resp_t, DATA_BUS_WIDTH, ID_BUS_WIDTH, burst/resp constants.
- Natural sub-module: dma_byte_aligner (combinational). Inputs rdata, src_off, dst_off, chunk; outputs wdata and wstrb.
- The companion master mux is a separate combinational block outside this one:
  - master_ctrl=1 routes axi_req_o of this block to RAM and returns the RAM response to it.
  - master_ctrl=0 selects the BFM instead.
  - The unselected master sees all ready and valid response signals forced to 0.

Test Plan:
- Unaligned copy: RAM 0x1100_0100..0x13F preloaded with byte(i)=i; desc {src 0x1100_011B, dst 0x1400_0127, num_bytes 11}; go pulse.
  - Expect done within 60 cycles, errors clear.
  - Bytes at 0x1400_0127..0x131 equal 0x1B..0x25; neighbouring bytes untouched.
  - First write has wstrb=0x80.
- Aligned copy: src 0x1100_0100, dst 0x1400_0100, 64 bytes -> eight chunks, all wstrb=0xFF, destination identical to source, done=1.
- Zero length: num_bytes=0 -> no AXI valid ever asserted; done=1 two cycles after go.
- Error path: RAM returns rresp=SLVERR on the first read -> rd_err=1, err_addr=src, done=1, no AW issued. Separately, bresp=SLVERR -> wr_err=1, err_addr=dst.
- Go while busy: second go 3 cycles into the first transfer -> ignored; the descriptor is not re-latched; the first transfer completes normally.
- Reset mid-transfer: rst=1 for 1 cycle during WR_AW_W -> next cycle all valids=0, busy=0, done=0; a subsequent go works.
